fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter N_INPUTS, default 4, number of requesting FIFOs (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, word width, matches attached FIFO DATA_WIDTH.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 empty_i  input  N_INPUTS  per-FIFO empty flag, bit k from FIFO k empty_o.
REQ-006 data_i  input  N_INPUTS*DATA_WIDTH  per-FIFO read data, slice k = FIFO k data_o.
REQ-007 rd_en_o  output  N_INPUTS  per-FIFO read enable, at most one bit high.
REQ-008 data_o  output  DATA_WIDTH  registered output word.
REQ-009 valid_o  output  1  data_o holds an undelivered word.
REQ-010 ready_i  input  1  downstream accepts data_o when valid_o && ready_i.
REQ-011 grant_o  output  N_INPUTS  one-hot index of input currently served, zero in IDLE.
REQ-012 busy_o  output  1  FSM not in IDLE.

Function
REQ-013 FSM states: IDLE, FETCH, CAPTURE, PRESENT; Moore outputs only.
REQ-014 IDLE: if empty_i != all-ones, register grant = first k with empty_i[k]==0 scanning ptr, ptr+1, ... mod N_INPUTS; go FETCH; else stay.
REQ-015 FETCH: rd_en_o[grant]=1 for exactly one cycle; go CAPTURE.
REQ-016 CAPTURE: load data_i slice[grant] into data_o at end of cycle (FIFO one-cycle read latency); go PRESENT.
REQ-017 PRESENT: valid_o=1; data_o stable; on ready_i=1 go IDLE and set ptr = (grant+1) mod N_INPUTS; else hold.
REQ-018 Latency: empty_i[k] falls before edge 0 with FSM in IDLE -> rd_en_o[k] high cycle 1 -> valid_o high cycle 3; max throughput one word per 4 cycles.
REQ-019 ptr width = clog2(N_INPUTS); wrap N_INPUTS-1 -> 0 explicit, including non-power-of-2 N_INPUTS.
REQ-020 Grant only sampled in IDLE; empty_i changes during FETCH/CAPTURE/PRESENT ignored.
REQ-021 Never assert rd_en_o to an input whose empty_i was 1 at grant time (no FIFO underflow).
REQ-022 Input with ptr index and request wins ties; a continuously requesting input is served within N_INPUTS grants.
REQ-023 rd_en_o zero in IDLE, CAPTURE, PRESENT.

Reset
REQ-024 rst_i high asynchronously forces: state IDLE, ptr 0, grant 0, data_o 0, valid_o 0, rd_en_o 0, grant_o 0, busy_o 0.
REQ-025 Reset mid-transfer discards the held/fetched word; no rd_en_o glitch during or on release; first grant after release uses ptr 0.

Structure
REQ-026 Shared package arb_pkg holds state encodings (2-bit, IDLE=0, FETCH=1, CAPTURE=2, PRESENT=3) and clog2 helper.
REQ-027 Combinational sub-module rr_picker (inputs req, ptr; outputs one-hot grant, valid) instantiated once.
REQ-028 Single output register stage; no internal word buffering beyond data_o.

Verification
REQ-029 N=4, FIFO0 holds 0xA1, others empty, ready_i=1 -> rd_en_o=0001 cycle 1, valid_o cycle 3 with data_o=0xA1, ptr=1 after.
REQ-030 All four FIFOs hold 2 words (0x10+k, 0x20+k), ready_i=1 -> output order 0x10,0x11,0x12,0x13,0x20,0x21,0x22,0x23.
REQ-031 ptr=3, FIFO3 and FIFO0 non-empty -> grant 1000 then 0001 (wrap-around).
REQ-032 ready_i=0 for 10 cycles in PRESENT -> data_o/valid_o stable, rd_en_o=0 throughout; ready_i=1 -> IDLE next cycle.
REQ-033 rst_i asserted during FETCH -> rd_en_o=0 and valid_o=0 immediately; after release FIFO word count reduced by at most one, no underflow_o.
REQ-034 N_INPUTS=3, all requesting for 9 grants -> each input granted exactly 3 times, ptr sequence 1,2,0 repeating.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM encoding and sizing helper for the FIFO round-robin arbiter
package arb_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      PRESENT = 2'd3
   } state_t;

   // Bits needed to index n items, never less than one
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: picks the first requester at or after ptr, wrapping modulo N
module rr_picker
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic          valid_o
);
   int w_off, w_best;

   // Requester with the smallest rotated distance from ptr wins
   always_comb begin
      grant_o = '0;
      w_best  = N;
      w_off   = 0;
      for (int k = 0; k < N; k++) begin
         w_off = (k >= int'(ptr_i)) ? k - int'(ptr_i) : k + N - int'(ptr_i);
         if (req_i[k] && w_off < w_best) begin
            w_best     = w_off;
            grant_o    = '0;
            grant_o[k] = 1'b1;
         end
      end
   end

   assign valid_o = |req_i;
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin reader of N FIFOs into one registered output word
module fifo_rr_arbiter
   import arb_pkg::*;
#(
   parameter int N_INPUTS   = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [N_INPUTS-1:0]            empty_i,
   input  logic [N_INPUTS*DATA_WIDTH-1:0] data_i,
   output logic [N_INPUTS-1:0]            rd_en_o,
   output logic [DATA_WIDTH-1:0]          data_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [N_INPUTS-1:0]            grant_o,
   output logic                           busy_o
);
   localparam int PW = clog2(N_INPUTS);

   state_t                r_state, w_next;
   logic [PW-1:0]         r_ptr, w_gidx;
   logic [N_INPUTS-1:0]   r_grant, w_pick;
   logic                  w_pick_vld;
   logic [DATA_WIDTH-1:0] r_data, w_sel;

   rr_picker #(.N(N_INPUTS), .PW(PW)) u_picker (
      .req_i   (~empty_i),
      .ptr_i   (r_ptr),
      .grant_o (w_pick),
      .valid_o (w_pick_vld)
   );

   // State register
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;

   // Next state: one fixed pass FETCH -> CAPTURE -> PRESENT per granted word
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_pick_vld) w_next = FETCH;
         FETCH:   w_next = CAPTURE;
         CAPTURE: w_next = PRESENT;
         PRESENT: if (ready_i) w_next = IDLE;
      endcase
   end

   // Granted slice and its index, decoded from the registered one-hot grant
   always_comb begin
      w_sel  = '0;
      w_gidx = '0;
      for (int k = 0; k < N_INPUTS; k++)
         if (r_grant[k]) begin
            w_sel  = w_sel | data_i[k*DATA_WIDTH +: DATA_WIDTH];
            w_gidx = PW'(k);
         end
   end

   // Grant latched only in IDLE, word captured one cycle after the FIFO read, ptr advanced on handoff
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_ptr   <= '0;
         r_grant <= '0;
         r_data  <= '0;
      end else begin
         if (r_state == IDLE && w_pick_vld) r_grant <= w_pick;
         if (r_state == CAPTURE) r_data <= w_sel;
         if (r_state == PRESENT && ready_i) begin
            r_ptr   <= (w_gidx == PW'(N_INPUTS - 1)) ? '0 : w_gidx + PW'(1);
            r_grant <= '0;
         end
      end

   // Moore outputs decoded from state
   always_comb begin
      rd_en_o = (r_state == FETCH) ? r_grant : '0;
      valid_o = r_state == PRESENT;
      busy_o  = r_state != IDLE;
      grant_o = r_grant;
   end

   assign data_o = r_data;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: FIFO models, output scoreboard and directed scenarios for the arbiter
module tb_fifo_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1, ready = 1'b1;
   logic [3:0]  empty = '1, rd_en, grant, rd_pend = '0;
   logic [31:0] din = '0;
   logic [7:0]  dout;
   logic        valid, busy;
   logic [7:0]  q [4][$];
   logic [7:0]  exp_q [$];
   int          checks = 0, errors = 0;

   logic        rst3 = 1'b1;
   logic [2:0]  rd3, grant3;
   logic [23:0] din3 = 24'hC2C1C0;
   logic [7:0]  dout3;
   logic        valid3, busy3;

   always #5 clk = ~clk;

   fifo_rr_arbiter #(.N_INPUTS(4), .DATA_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst), .empty_i(empty), .data_i(din), .rd_en_o(rd_en),
      .data_o(dout), .valid_o(valid), .ready_i(ready), .grant_o(grant), .busy_o(busy)
   );

   fifo_rr_arbiter #(.N_INPUTS(3), .DATA_WIDTH(8)) dut3 (
      .clk_i(clk), .rst_i(rst3), .empty_i(3'b000), .data_i(din3), .rd_en_o(rd3),
      .data_o(dout3), .valid_o(valid3), .ready_i(1'b1), .grant_o(grant3), .busy_o(busy3)
   );

   // One clock: mid-cycle monitor and FIFO flags, then FIFO pops just after the edge
   task automatic tick();
      logic [7:0] e;
      @(negedge clk);
      rd_pend = rd_en;
      for (int k = 0; k < 4; k++) begin
         if (rd_en[k]) begin
            checks++;
            if (q[k].size() == 0 || !$onehot(rd_en)) begin
               errors++;
               $display("FAIL rd_en_safe k=%0d rd_en=%b depth=%0d required one-hot to non-empty FIFO", k, rd_en, q[k].size());
            end
         end
         empty[k] = (q[k].size() == 0);
      end
      if (valid && ready && !rst) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_extra got %h required no word", dout);
         end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin
               errors++;
               $display("FAIL scoreboard_data got %h required %h", dout, e);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         if (rd_pend[k] && q[k].size() != 0) din[k*8 +: 8] = q[k].pop_front();
   endtask

   task automatic push(input int k, input logic [7:0] v, input bit expect_out);
      q[k].push_back(v);
      if (expect_out) exp_q.push_back(v);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_drain words_left=%0d busy=%b required 0 and idle", name, exp_q.size(), busy);
      end
   endtask

   task automatic wait_rd(output logic [3:0] r);
      int n = 0;
      tick();
      while (rd_en == 0 && n < 50) begin
         tick();
         n++;
      end
      r = rd_en;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (rd_en !== 4'b0) begin errors++; $display("FAIL reset_rd_en got %b required 0000", rd_en); end
      checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b required 0000", grant); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", valid); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data got %h required 00", dout); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [3:0] r;
      push(0, 8'hA1, 1'b1);
      tick();
      checks++; if (rd_en !== 4'b0001) begin errors++; $display("FAIL single_rd_en_c1 got %b required 0001", rd_en); end
      checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single_grant_c1 got %b/%b required 0001/1", grant, busy); end
      tick();
      checks++; if (rd_en !== 4'b0 || valid !== 1'b0) begin errors++; $display("FAIL single_c2 rd_en=%b valid=%b required 0000/0", rd_en, valid); end
      tick();
      checks++; if (valid !== 1'b1 || dout !== 8'hA1) begin errors++; $display("FAIL single_c3 valid=%b data=%h required 1/a1", valid, dout); end
      wait_drain("single");
      push(0, 8'hB0, 1'b0);
      push(1, 8'hB1, 1'b0);
      exp_q.push_back(8'hB1);
      exp_q.push_back(8'hB0);
      wait_rd(r);
      checks++; if (r !== 4'b0010) begin errors++; $display("FAIL ptr1_first got %b required 0010", r); end
      wait_rd(r);
      checks++; if (r !== 4'b0001) begin errors++; $display("FAIL ptr1_second got %b required 0001", r); end
      wait_drain("ptr1");
   endtask

   task automatic test_order();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) push(k, 8'h10 + 8'(k), 1'b1);
      for (int k = 0; k < 4; k++) push(k, 8'h20 + 8'(k), 1'b1);
      wait_drain("order");
   endtask

   task automatic test_wrap();
      logic [3:0] r;
      push(2, 8'h32, 1'b1);
      wait_drain("to_ptr3");
      push(3, 8'h43, 1'b0);
      push(0, 8'h40, 1'b0);
      exp_q.push_back(8'h43);
      exp_q.push_back(8'h40);
      wait_rd(r);
      checks++; if (r !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b required 1000", r); end
      wait_rd(r);
      checks++; if (r !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b required 0001", r); end
      wait_drain("wrap");
   endtask

   task automatic test_stall();
      int n = 0;
      ready = 1'b0;
      push(1, 8'h55, 1'b1);
      while (!valid && n < 20) begin
         tick();
         n++;
      end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b required 1", valid); end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (valid !== 1'b1 || dout !== 8'h55 || rd_en !== 4'b0 || grant !== 4'b0010) begin
            errors++;
            $display("FAIL stall_hold cycle=%0d valid=%b data=%h rd_en=%b grant=%b required 1/55/0000/0010", i, valid, dout, rd_en, grant);
         end
      end
      ready = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL stall_release busy=%b valid=%b required 0/0", busy, valid); end
      wait_drain("stall");
   endtask

   task automatic test_reset_fetch();
      push(2, 8'h66, 1'b0);
      tick();
      checks++; if (rd_en !== 4'b0100) begin errors++; $display("FAIL rstfetch_rd_en got %b required 0100", rd_en); end
      #1 rst = 1'b1;
      #1;
      checks++; if (rd_en !== 4'b0 || valid !== 1'b0 || busy !== 1'b0 || grant !== 4'b0) begin
         errors++;
         $display("FAIL rstfetch_async rd_en=%b valid=%b busy=%b grant=%b required all zero", rd_en, valid, busy, grant);
      end
      repeat (2) begin
         tick();
         checks++; if (rd_en !== 4'b0) begin errors++; $display("FAIL rstfetch_hold rd_en=%b required 0000", rd_en); end
      end
      rst = 1'b0;
      checks++; if (q[2].size() != 1) begin errors++; $display("FAIL rstfetch_depth got %0d required 1", q[2].size()); end
      push(0, 8'h70, 1'b1);
      exp_q.push_back(8'h66);
      wait_drain("rstfetch");
   endtask

   task automatic test_n3();
      int cnt [3] = '{0, 0, 0};
      int n;
      rst3 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         n = 0;
         tick();
         while (rd3 == 0 && n < 50) begin
            tick();
            n++;
         end
         checks++;
         if (rd3 !== 3'(1 << (i % 3))) begin errors++; $display("FAIL n3_grant idx=%0d got %b required %b", i, rd3, 3'(1 << (i % 3))); end
         for (int j = 0; j < 3; j++) if (rd3[j]) cnt[j]++;
         tick();
         tick();
         checks++;
         if (valid3 !== 1'b1 || dout3 !== 8'hC0 + 8'(i % 3)) begin
            errors++;
            $display("FAIL n3_data idx=%0d valid=%b data=%h required 1/%h", i, valid3, dout3, 8'hC0 + 8'(i % 3));
         end
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (cnt[j] != 3) begin errors++; $display("FAIL n3_count input=%0d got %0d required 3", j, cnt[j]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_order();
      test_wrap();
      test_stall();
      test_reset_fetch();
      test_n3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule
